crc32_fcs_check: RTL and testbench
==================================

Name: crc32_fcs_check

Overview:
Receive-side Ethernet FCS checker, the counterpart of the team's 32-bit CRC32 generator. It consumes a 32-bit word stream carrying frame bytes plus the trailing 4-byte FCS and runs the same CRC32 polynomial over all of it. At end of frame it reports pass/fail against the fixed residue, the frame byte count, and truncation/runt conditions. It sits between the MAC receive aligner and the frame buffer write logic; there is no backpressure.

Parameters:
RESIDUE, 32'hC704DD7B, good-frame register value after all bytes including FCS, in the same bit convention as the team's crc32_d32.
INIT, 32'hFFFFFFFF, CRC register value loaded at start of frame.
LEN_W, 16, width of byte-length counter (saturating).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  word qualifier
in_sop  in  1  first word of frame, valid only with in_valid
in_eop  in  1  last word of frame, valid only with in_valid
in_be  in  2  valid bytes on eop word: 0=4, 1..3=that many, always starting at bits [7:0]; ignored when in_eop=0
in_data  in  32  frame bytes, byte 0 (wire order) in [7:0]
out_valid  out  1  one-cycle result strobe
out_fcs_ok  out  1  residue matched; qualified by out_valid
out_runt  out  1  frame shorter than 4 bytes
out_trunc  out  1  frame aborted by new sop before eop
out_len  out  LEN_W  bytes in frame including FCS, saturating
out_crc  out  32  final CRC register value (debug)

Behaviour:
- Reset: all outputs 0, state IDLE, CRC register = INIT, length = 0.
- FSM has two states, IDLE and FRAME.
- IDLE, with in_valid & in_sop:
  - crc = step32(INIT, in_data), len = 4.
  - If in_eop is also set, finish immediately using the tail rule; state stays IDLE.
  - Otherwise go to FRAME.
- IDLE, with in_valid and no in_sop: word ignored, no output.
- FRAME, with in_valid and no sop/eop: crc = step32(crc, in_data), len += 4, saturating at all-ones.
- FRAME, with in_valid & in_eop & !in_sop:
  - Full word (be=0): step32.
  - Partial word (be=n): n sequential step8 on bytes [7:0], [15:8], ... in order.
  - len += 4 or n.
  - Result is registered; go to IDLE.
- FRAME, with in_valid & in_sop:
  - Abort the current frame: next cycle out_valid=1, out_trunc=1, out_fcs_ok=0, out_len = bytes so far.
  - The new word starts a new frame exactly as from IDLE, including the sop&eop case.
  - If sop&eop, that frame's result strobes on the following cycle.
  - The two results are never merged; one extra flop holds the pending result.
- Result timing: out_valid is high exactly one clk after the accepting eop edge.
  - out_fcs_ok = (final crc == RESIDUE) && !runt.
  - out_runt = total len < 4. It occurs only on sop&eop with be 1..3.
  - Runt CRC is still computed and reported on out_crc.
- Result outputs hold their values until the next out_valid; out_valid itself is a pulse.
- Gaps (in_valid=0) inside a frame are allowed and change nothing.
- Consistency rule: step8 equations use the same generator and bit ordering as crc32_d32. Four step8 calls on bytes [7:0] then [31:24] must equal one step32 call. The bench checks this.
- rst_n low mid-frame: immediate return to IDLE, frame discarded, no out_valid.

Optional Feature:
CRC_FCS_STAT_EN
- Defined: adds outputs stat_good, stat_bad, stat_runt, stat_trunc, each 32-bit and saturating.
  - Each increments on the out_valid cycle matching its category. Bad means a non-runt, non-trunc FCS failure.
  - Input stat_clr (1 bit) zeroes all four synchronously; a clear wins over a simultaneous increment.
  - All four reset to 0.
- Undefined: these ports and the logic behind them do not exist.

Decomposition:
- Package crc32_pkg holds:
  - localparam CRC32_POLY = 32'h04C11DB7, CRC32_INIT, CRC32_RESIDUE;
  - typedef crc32_t (32-bit);
  - functions crc32_step8 and crc32_step32, shared with the generator side.
- One sub-module, crc32_tail_step: combinational; inputs crc, data, be; output is the crc after 1..4 bytes. It keeps tail muxing out of the FSM.
- Counters live in the top level under the macro.

Test Plan:
- Good frame: 60-byte payload plus correct FCS from the bench model, 16 back-to-back words → single out_valid one cycle after eop, fcs_ok=1, len=64, crc=32'hC704DD7B.
- Tail widths: 65-, 66- and 67-byte frames (eop be=1,2,3) with correct FCS → fcs_ok=1, len=65/66/67. Flip bit 3 of the last byte → fcs_ok=0.
- Runt and gaps: sop&eop with be=3 → runt=1, fcs_ok=0, len=3. A 64-byte good frame with random in_valid gaps → same result as without gaps.
- Abort then single-word frame: sop, 2 words, then sop&eop be=0 (4 FCS bytes of an empty frame) → first strobe trunc=1 len=8, next cycle second strobe trunc=0 len=4.
- Reset mid-frame: rst_n pulsed low after word 5 of 16 → no out_valid. The following good 64-byte frame → fcs_ok=1.
- Stats (macro defined): 3 good, 1 bad, 1 runt, 1 trunc frames → stat_good=3, stat_bad=1, stat_runt=1, stat_trunc=1. stat_clr coincident with a good out_valid → stat_good=0.

Source files
------------

// File: rtl/crc32_pkg.sv
// Shared CRC32 definitions for the Ethernet FCS generator and checker.
// Bit convention: MSB-first register, poly 04C11DB7, each byte fed LSB first.
package crc32_pkg;

   localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

   typedef logic [31:0] crc32_t;

   typedef enum logic {
      ST_IDLE,
      ST_FRAME
   } fcs_state_e;

   function automatic crc32_t crc32_step8(input crc32_t crc, input logic [7:0] data);
      crc32_t c;
      c = crc;
      for (int i = 0; i < 8; i++) begin
         if (c[31] ^ data[i]) c = (c << 1) ^ CRC32_POLY;
         else                 c = c << 1;
      end
      return c;
   endfunction

   // Byte 0 (bits [7:0]) is the first byte on the wire.
   function automatic crc32_t crc32_step32(input crc32_t crc, input logic [31:0] data);
      crc32_t c;
      c = crc;
      for (int b = 0; b < 4; b++) begin
         c = crc32_step8(c, data[8*b +: 8]);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_fcs_check_if.sv
// Word stream into the FCS checker and the per-frame result coming back out.
interface crc32_fcs_check_if #(
   parameter int LEN_W = 16
);
   logic             in_valid;
   logic             in_sop;
   logic             in_eop;
   logic [1:0]       in_be;
   logic [31:0]      in_data;
   logic             out_valid;
   logic             out_fcs_ok;
   logic             out_runt;
   logic             out_trunc;
   logic [LEN_W-1:0] out_len;
   logic [31:0]      out_crc;

   modport master (
      output in_valid, in_sop, in_eop, in_be, in_data,
      input  out_valid, out_fcs_ok, out_runt, out_trunc, out_len, out_crc
   );

   modport slave (
      input  in_valid, in_sop, in_eop, in_be, in_data,
      output out_valid, out_fcs_ok, out_runt, out_trunc, out_len, out_crc
   );
endinterface

// File: rtl/crc32_tail_step.sv
// Combinational CRC update over 1..4 bytes of a word; be=0 means all four bytes.
module crc32_tail_step
   import crc32_pkg::*;
(
   input  crc32_t      crc,
   input  logic [31:0] data,
   input  logic [1:0]  be,
   output crc32_t      crc_out
);

   always_comb begin
      crc_out = crc;
      if (be == 2'd0) begin
         crc_out = crc32_step32(crc, data);
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (2'(i) < be) crc_out = crc32_step8(crc_out, data[8*i +: 8]);
         end
      end
   end

endmodule

// File: rtl/crc32_fcs_check.sv
// Receive-side Ethernet FCS checker: CRC32 over frame + FCS, compared to the fixed residue.
// Optional saturating per-category frame counters when CRC_FCS_STAT_EN is defined.
module crc32_fcs_check
   import crc32_pkg::*;
#(
   parameter crc32_t RESIDUE = CRC32_RESIDUE,
   parameter crc32_t INIT    = CRC32_INIT,
   parameter int     LEN_W   = 16
) (
   input  logic clk,
   input  logic rst_n,
   crc32_fcs_check_if.slave bus
`ifdef CRC_FCS_STAT_EN
   ,
   input  logic        stat_clr,
   output logic [31:0] stat_good,
   output logic [31:0] stat_bad,
   output logic [31:0] stat_runt,
   output logic [31:0] stat_trunc
`endif
);

   fcs_state_e       state;
   crc32_t           crc_q;
   logic [LEN_W-1:0] len_q;

   crc32_t           base_crc;
   crc32_t           word_crc;
   logic [LEN_W-1:0] base_len;
   logic [LEN_W-1:0] word_len;
   logic [LEN_W:0]   len_sum;
   logic [1:0]       tail_be;
   logic [2:0]       word_bytes;
   logic             accept;
   logic             abort;
   logic             finish;
   logic             word_runt;
   logic             word_ok;

   logic             res_valid;
   logic             res_fcs_ok;
   logic             res_runt;
   logic             res_trunc;
   logic [LEN_W-1:0] res_len;
   crc32_t           res_crc;

   logic             pend_valid;
   logic             pend_fcs_ok;
   logic             pend_runt;
   logic [LEN_W-1:0] pend_len;
   crc32_t           pend_crc;

   crc32_tail_step u_tail (
      .crc     (base_crc),
      .data    (bus.in_data),
      .be      (tail_be),
      .crc_out (word_crc)
   );

   // A sop always restarts from INIT/zero, whether from IDLE or aborting a frame.
   always_comb begin
      accept     = bus.in_valid && (bus.in_sop || (state == ST_FRAME));
      abort      = bus.in_valid && bus.in_sop && (state == ST_FRAME);
      finish     = accept && bus.in_eop;
      base_crc   = bus.in_sop ? INIT : crc_q;
      base_len   = bus.in_sop ? '0 : len_q;
      tail_be    = bus.in_eop ? bus.in_be : 2'd0;
      word_bytes = (tail_be == 2'd0) ? 3'd4 : {1'b0, tail_be};
      len_sum    = {1'b0, base_len} + {{(LEN_W-2){1'b0}}, word_bytes};
      word_len   = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
      word_runt  = (word_len < LEN_W'(4));
      word_ok    = (word_crc == RESIDUE) && !word_runt;
   end

   // An abort followed by sop&eop yields two results on one edge; the second waits in pend_*.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         crc_q       <= INIT;
         len_q       <= '0;
         res_valid   <= 1'b0;
         res_fcs_ok  <= 1'b0;
         res_runt    <= 1'b0;
         res_trunc   <= 1'b0;
         res_len     <= '0;
         res_crc     <= '0;
         pend_valid  <= 1'b0;
         pend_fcs_ok <= 1'b0;
         pend_runt   <= 1'b0;
         pend_len    <= '0;
         pend_crc    <= '0;
      end else begin
         res_valid  <= 1'b0;
         pend_valid <= 1'b0;
         if (accept) begin
            crc_q <= word_crc;
            len_q <= word_len;
            state <= finish ? ST_IDLE : ST_FRAME;
         end
         if (pend_valid) begin
            res_valid  <= 1'b1;
            res_fcs_ok <= pend_fcs_ok;
            res_runt   <= pend_runt;
            res_trunc  <= 1'b0;
            res_len    <= pend_len;
            res_crc    <= pend_crc;
         end else if (abort) begin
            res_valid  <= 1'b1;
            res_fcs_ok <= 1'b0;
            res_runt   <= 1'b0;
            res_trunc  <= 1'b1;
            res_len    <= len_q;
            res_crc    <= crc_q;
         end else if (finish) begin
            res_valid  <= 1'b1;
            res_fcs_ok <= word_ok;
            res_runt   <= word_runt;
            res_trunc  <= 1'b0;
            res_len    <= word_len;
            res_crc    <= word_crc;
         end
         if (finish && (pend_valid || abort)) begin
            pend_valid  <= 1'b1;
            pend_fcs_ok <= word_ok;
            pend_runt   <= word_runt;
            pend_len    <= word_len;
            pend_crc    <= word_crc;
         end
      end
   end

   assign bus.out_valid  = res_valid;
   assign bus.out_fcs_ok = res_fcs_ok;
   assign bus.out_runt   = res_runt;
   assign bus.out_trunc  = res_trunc;
   assign bus.out_len    = res_len;
   assign bus.out_crc    = res_crc;

`ifdef CRC_FCS_STAT_EN
   // Counters sample the registered strobe; a clear beats a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_good  <= '0;
         stat_bad   <= '0;
         stat_runt  <= '0;
         stat_trunc <= '0;
      end else if (stat_clr) begin
         stat_good  <= '0;
         stat_bad   <= '0;
         stat_runt  <= '0;
         stat_trunc <= '0;
      end else if (res_valid) begin
         if (res_fcs_ok && (stat_good != '1))  stat_good  <= stat_good + 32'd1;
         if (res_runt   && (stat_runt != '1))  stat_runt  <= stat_runt + 32'd1;
         if (res_trunc  && (stat_trunc != '1)) stat_trunc <= stat_trunc + 32'd1;
         if (!res_fcs_ok && !res_runt && !res_trunc && (stat_bad != '1))
            stat_bad <= stat_bad + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_crc32_fcs_check.sv
// Directed testbench for crc32_fcs_check using an independent reflected CRC32 model.
// Stat counter checks are compiled in when CRC_FCS_STAT_EN is defined.
module tb_crc32_fcs_check;
   import crc32_pkg::*;

   typedef logic [7:0] bq_t[$];

   localparam logic [31:0] GOOD_RES = 32'hC704DD7B;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   fails  = 0;

`ifdef CRC_FCS_STAT_EN
   logic        stat_clr;
   logic [31:0] stat_good;
   logic [31:0] stat_bad;
   logic [31:0] stat_runt;
   logic [31:0] stat_trunc;
`endif

   crc32_fcs_check_if #(.LEN_W(16)) bus ();

   crc32_fcs_check #(.LEN_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef CRC_FCS_STAT_EN
      ,
      .stat_clr   (stat_clr),
      .stat_good  (stat_good),
      .stat_bad   (stat_bad),
      .stat_runt  (stat_runt),
      .stat_trunc (stat_trunc)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: LSB-first reflected CRC32 (poly EDB88320), no final inversion.
   function automatic logic [31:0] ref_crc(input bq_t b);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (b[i]) begin
         c = c ^ {24'h0, b[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   function automatic bq_t make_frame(input int n, input int seed);
      bq_t b;
      logic [31:0] fcs;
      for (int i = 0; i < n; i++) b.push_back(8'((i * 7 + seed * 13) & 255));
      fcs = ~ref_crc(b);
      b.push_back(fcs[7:0]);
      b.push_back(fcs[15:8]);
      b.push_back(fcs[23:16]);
      b.push_back(fcs[31:24]);
      return b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.in_valid = 1'b0;
      bus.in_sop   = 1'b0;
      bus.in_eop   = 1'b0;
      bus.in_be    = 2'd0;
      bus.in_data  = 32'h0;
   endtask

   task automatic drive_word(input bit sop, input bit eop, input logic [1:0] be,
                             input logic [31:0] data);
      bus.in_valid = 1'b1;
      bus.in_sop   = sop;
      bus.in_eop   = eop;
      bus.in_be    = be;
      bus.in_data  = data;
      @(posedge clk);
      #1;
   endtask

   task automatic send_words(input bq_t b, input int w_from, input int w_to, input bit gaps);
      int n;
      int nw;
      logic [31:0] d;
      n  = b.size();
      nw = (n + 3) / 4;
      for (int w = w_from; w <= w_to; w++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               idle_inputs();
               @(posedge clk);
               #1;
            end
         end
         d = 32'h0;
         for (int k = 0; k < 4; k++) if (4 * w + k < n) d[8*k +: 8] = b[4*w+k];
         drive_word(w == 0, w == nw - 1, (w == nw - 1) ? 2'(n % 4) : 2'd0, d);
      end
      idle_inputs();
   endtask

   task automatic send_frame(input bq_t b, input bit gaps);
      send_words(b, 0, (b.size() + 3) / 4 - 1, gaps);
   endtask

   task automatic check_result(input string tag, input bit ok, input bit runt, input bit trunc,
                               input int len, input logic [31:0] crc);
      chk({tag, "_valid"}, 32'(bus.out_valid), 32'(1));
      chk({tag, "_fcs_ok"}, 32'(bus.out_fcs_ok), 32'(ok));
      chk({tag, "_runt"}, 32'(bus.out_runt), 32'(runt));
      chk({tag, "_trunc"}, 32'(bus.out_trunc), 32'(trunc));
      chk({tag, "_len"}, 32'(bus.out_len), 32'(len));
      chk({tag, "_crc"}, bus.out_crc, crc);
   endtask

   initial begin
      bq_t f;
      bq_t w8;
      logic [31:0] s32;
      logic [31:0] s8;
      logic [31:0] word;

      rst_n = 1'b0;
      idle_inputs();
`ifdef CRC_FCS_STAT_EN
      stat_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.out_valid), 32'(0));
      chk("rst_fcs_ok", 32'(bus.out_fcs_ok), 32'(0));
      chk("rst_runt", 32'(bus.out_runt), 32'(0));
      chk("rst_trunc", 32'(bus.out_trunc), 32'(0));
      chk("rst_len", 32'(bus.out_len), 32'(0));
      chk("rst_crc", bus.out_crc, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      word = 32'hDEADBEEF;
      s32 = crc32_step32(CRC32_INIT, word);
      s8  = CRC32_INIT;
      for (int k = 0; k < 4; k++) s8 = crc32_step8(s8, word[8*k +: 8]);
      chk("step32_vs_step8", s32, s8);
      w8 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      chk("step32_vs_model", s32, bitrev32(ref_crc(w8)));

      f = make_frame(60, 1);
      send_frame(f, 1'b0);
      check_result("good64", 1'b1, 1'b0, 1'b0, 64, GOOD_RES);
      @(posedge clk);
      #1;
      chk("good64_pulse", 32'(bus.out_valid), 32'(0));
      chk("good64_hold_len", 32'(bus.out_len), 32'(64));

      for (int n = 61; n <= 63; n++) begin
         f = make_frame(n, n);
         send_frame(f, 1'b0);
         check_result($sformatf("tail%0d", n + 4), 1'b1, 1'b0, 1'b0, n + 4, GOOD_RES);
      end

      f = make_frame(63, 5);
      f[66] = f[66] ^ 8'h08;
      send_frame(f, 1'b0);
      check_result("bad_bit3", 1'b0, 1'b0, 1'b0, 67, bitrev32(ref_crc(f)));

      drive_word(1'b1, 1'b1, 2'd3, 32'hAA332211);
      idle_inputs();
      w8 = '{8'h11, 8'h22, 8'h33};
      check_result("runt3", 1'b0, 1'b1, 1'b0, 3, bitrev32(ref_crc(w8)));

      f = make_frame(60, 9);
      send_frame(f, 1'b1);
      check_result("gaps64", 1'b1, 1'b0, 1'b0, 64, GOOD_RES);

      f = make_frame(60, 3);
      send_words(f, 0, 1, 1'b0);
      drive_word(1'b1, 1'b1, 2'd0, 32'h0);
      idle_inputs();
      w8 = f[0:7];
      check_result("abort_trunc", 1'b0, 1'b0, 1'b1, 8, bitrev32(ref_crc(w8)));
      @(posedge clk);
      #1;
      check_result("abort_next", 1'b1, 1'b0, 1'b0, 4, GOOD_RES);
      @(posedge clk);
      #1;
      chk("abort_pulse_end", 32'(bus.out_valid), 32'(0));

      f = make_frame(60, 11);
      send_words(f, 0, 4, 1'b0);
      #2;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_len", 32'(bus.out_len), 32'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_words(f, 5, 15, 1'b0);
      chk("midrst_no_valid", 32'(bus.out_valid), 32'(0));
      chk("midrst_no_result", 32'(bus.out_len), 32'(0));
      f = make_frame(60, 12);
      send_frame(f, 1'b0);
      check_result("after_rst", 1'b1, 1'b0, 1'b0, 64, GOOD_RES);

`ifdef CRC_FCS_STAT_EN
      stat_clr = 1'b1;
      @(posedge clk);
      #1;
      stat_clr = 1'b0;
      send_frame(make_frame(60, 20), 1'b0);
      send_frame(make_frame(61, 21), 1'b0);
      f = make_frame(62, 22);
      f[64] = f[64] ^ 8'h08;
      send_frame(f, 1'b0);
      drive_word(1'b1, 1'b1, 2'd2, 32'h00005A5A);
      f = make_frame(60, 23);
      send_words(f, 0, 1, 1'b0);
      send_frame(make_frame(60, 24), 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("stat_good", stat_good, 32'd3);
      chk("stat_bad", stat_bad, 32'd1);
      chk("stat_runt", stat_runt, 32'd1);
      chk("stat_trunc", stat_trunc, 32'd1);
      send_frame(make_frame(60, 25), 1'b0);
      chk("stat_clr_strobe", 32'(bus.out_valid), 32'(1));
      stat_clr = 1'b1;
      @(posedge clk);
      #1;
      stat_clr = 1'b0;
      chk("stat_clr_good", stat_good, 32'd0);
      chk("stat_clr_trunc", stat_trunc, 32'd0);
`endif

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
